// File: rtl/simd_warp_core.sv
// SIMD warp core: one sequencer issues each instruction to NUM_LANES lockstep lanes,
// each with a private register file, a per-lane execution mask and handshaked EMIT output.
module simd_warp_core #(
    parameter int NUM_LANES  = 8,
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 16,
    parameter int IMEM_DEPTH = 256,
    localparam int PC_W      = $clog2(IMEM_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          prog_valid,
    input  logic [PC_W-1:0]               prog_addr,
    input  logic [31:0]                   prog_data,
    output logic                          prog_ready,
    input  logic                          start_valid,
    input  logic [PC_W-1:0]               start_pc,
    input  logic [NUM_LANES*DATA_W-1:0]   start_data,
    input  logic [NUM_LANES-1:0]          start_mask,
    output logic                          start_ready,
    output logic                          out_valid,
    output logic [NUM_LANES*DATA_W-1:0]   out_data,
    output logic [NUM_LANES-1:0]          out_mask,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [PC_W-1:0] PC_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_EMIT} state_t;

    state_t                        state, state_nxt;
    logic [31:0]                   imem [IMEM_DEPTH];
    logic [31:0]                   instr_p0;
    logic [DATA_W-1:0]             rf [NUM_LANES][NUM_REGS];
    logic [PC_W-1:0]               pc;
    logic [NUM_LANES-1:0]          mask, saved_mask;
    logic                          err_r, done_r;
    logic [NUM_LANES*DATA_W-1:0]   out_data_r;
    logic [NUM_LANES-1:0]          out_mask_r;

    logic [3:0]                    op, rd, rs1, rs2;
    logic [15:0]                   imm;
    logic signed [DATA_W-1:0]      imm_sx;
    logic [DATA_W-1:0]             lui_val;
    logic [PC_W-1:0]               br_off;
    logic                          launch, prog_we, wr_en, any_taken;
    logic [DATA_W-1:0]             rs1_val [NUM_LANES];
    logic [DATA_W-1:0]             rs2_val [NUM_LANES];
    logic [DATA_W-1:0]             alu_res [NUM_LANES];
    logic [NUM_LANES-1:0]          nz;
    logic [NUM_LANES*DATA_W-1:0]   emit_data;

    function automatic logic reg_ok(input logic [3:0] idx);
        return (idx != 4'd0) && ({1'b0, idx} < 5'(NUM_REGS));
    endfunction

    function automatic logic [DATA_W-1:0] alu(input logic [3:0] opc,
                                              input logic signed [DATA_W-1:0] a,
                                              input logic signed [DATA_W-1:0] b,
                                              input logic signed [DATA_W-1:0] im,
                                              input logic [DATA_W-1:0] lui);
        case (opc)
            4'h0:    alu = a + b;
            4'h1:    alu = a - b;
            4'h2:    alu = a & b;
            4'h3:    alu = a | b;
            4'h4:    alu = a ^ b;
            4'h5:    alu = (a < b) ? DATA_W'(1) : '0;
            4'h6:    alu = a * b;
            4'h7:    alu = a + im;
            4'h8:    alu = lui;
            default: alu = '0;
        endcase
    endfunction

    assign op      = instr_p0[31:28];
    assign rd      = instr_p0[27:24];
    assign rs1     = instr_p0[23:20];
    assign rs2     = instr_p0[19:16];
    assign imm     = instr_p0[15:0];
    assign imm_sx  = DATA_W'($signed(imm));
    assign lui_val = DATA_W'({imm, 16'h0000});
    assign br_off  = PC_W'(imm_sx);

    // Programming wins over launch when both are requested in IDLE.
    assign prog_we = (state == S_IDLE) && prog_valid;
    assign launch  = (state == S_IDLE) && !prog_valid && start_valid;
    assign wr_en   = (state == S_EXEC) && (op <= 4'h8) && reg_ok(rd);

    always_comb begin
        emit_data = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            rs1_val[l] = reg_ok(rs1) ? rf[l][rs1[RIDX_W-1:0]] : '0;
            rs2_val[l] = reg_ok(rs2) ? rf[l][rs2[RIDX_W-1:0]] : '0;
            nz[l]      = |rs1_val[l];
            alu_res[l] = alu(op, rs1_val[l], rs2_val[l], imm_sx, lui_val);
            if (mask[l])
                emit_data[l*DATA_W +: DATA_W] = rs1_val[l];
        end
    end

    assign any_taken = |(mask & nz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy        = (state != S_IDLE);
        prog_ready  = (state == S_IDLE);
        start_ready = (state == S_IDLE) && !prog_valid;
        out_valid   = (state == S_EMIT);
        case (state)
            S_IDLE:  if (launch) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC: begin
                case (op)
                    4'hC:                state_nxt = S_EMIT;
                    4'hD, 4'hE, 4'hF:    state_nxt = S_IDLE;
                    default:             state_nxt = S_FETCH;
                endcase
            end
            S_EMIT:  if (out_ready) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            mask       <= '0;
            saved_mask <= '0;
            err_r      <= 1'b0;
            done_r     <= 1'b0;
            out_data_r <= '0;
            out_mask_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        pc         <= start_pc;
                        mask       <= start_mask;
                        saved_mask <= start_mask;
                        err_r      <= 1'b0;
                    end
                end
                S_EXEC: begin
                    case (op)
                        4'h9: begin
                            saved_mask <= mask;
                            mask       <= mask & nz;
                            pc         <= pc + PC_ONE;
                        end
                        4'hA: begin
                            mask <= saved_mask;
                            pc   <= pc + PC_ONE;
                        end
                        4'hB: pc <= any_taken ? pc + br_off : pc + PC_ONE;
                        4'hC: begin
                            out_data_r <= emit_data;
                            out_mask_r <= mask;
                        end
                        4'hD, 4'hE: begin
                            err_r  <= 1'b1;
                            done_r <= 1'b1;
                        end
                        4'hF:    done_r <= 1'b1;
                        default: pc <= pc + PC_ONE;
                    endcase
                end
                S_EMIT: if (out_ready) pc <= pc + PC_ONE;
                default: ;
            endcase
        end
    end

    // Storage arrays and the fetch register carry no reset.
    always_ff @(posedge clk) begin
        if (prog_we)
            imem[prog_addr] <= prog_data;
        if (state == S_FETCH)
            instr_p0 <= imem[pc];
        for (int l = 0; l < NUM_LANES; l++) begin
            if (launch)
                rf[l][1] <= start_data[l*DATA_W +: DATA_W];
            else if (wr_en && mask[l])
                rf[l][rd[RIDX_W-1:0]] <= alu_res[l];
        end
    end

    assign out_data = out_data_r;
    assign out_mask = out_mask_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_simd_warp_core.sv
// Scoreboard bench for simd_warp_core: expected EMIT payloads are queued at launch and
// compared as the core presents them; each scenario task checks its own control outputs.
module tb_simd_warp_core;

    localparam int NL  = 8;
    localparam int DW  = 32;
    localparam int PCW = 8;

    logic              clk, rst_n;
    logic              prog_valid, prog_ready, start_valid, start_ready;
    logic [PCW-1:0]    prog_addr, start_pc;
    logic [31:0]       prog_data;
    logic [NL*DW-1:0]  start_data, out_data;
    logic [NL-1:0]     start_mask, out_mask;
    logic              out_valid, out_ready, busy, done, err;

    typedef struct packed {
        logic [NL*DW-1:0] data;
        logic [NL-1:0]    mask;
    } emit_t;

    emit_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    simd_warp_core #(.NUM_LANES(NL), .DATA_W(DW), .NUM_REGS(16), .IMEM_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_valid(prog_valid), .prog_addr(prog_addr), .prog_data(prog_data), .prog_ready(prog_ready),
        .start_valid(start_valid), .start_pc(start_pc), .start_data(start_data),
        .start_mask(start_mask), .start_ready(start_ready),
        .out_valid(out_valid), .out_data(out_data), .out_mask(out_mask), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic prog_write(input logic [PCW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        prog_valid = 1'b1; prog_addr = a; prog_data = d;
        #1;
        checks++;
        if (prog_ready !== 1'b1) begin
            errors++; $display("FAIL prog_ready addr=%0d got=%b want=1", a, prog_ready);
        end
        @(negedge clk);
        prog_valid = 1'b0;
    endtask

    task automatic launch(input logic [PCW-1:0] pc, input logic [NL*DW-1:0] sd,
                          input logic [NL-1:0] m);
        @(negedge clk);
        start_valid = 1'b1; start_pc = pc; start_data = sd; start_mask = m;
        #1;
        checks++;
        if (start_ready !== 1'b1) begin
            errors++; $display("FAIL start_ready pc=%0d got=%b want=1", pc, start_ready);
        end
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [NL*DW-1:0] d, input logic [NL-1:0] m);
        emit_t e;
        e.data = d; e.mask = m;
        exp_q.push_back(e);
    endtask

    // Samples once per negedge: scores every accepted EMIT, stops at done.
    task automatic run_until_done(input string tag, input int max_cyc, output int first_emit);
        bit saw_done;
        emit_t e;
        saw_done   = 1'b0;
        first_emit = -1;
        for (int c = 0; c < max_cyc; c++) begin
            if (out_valid && out_ready) begin
                if (first_emit < 0) first_emit = c + 1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL %s unexpected_emit got data=%h mask=%h", tag, out_data, out_mask);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_mask !== e.mask) begin
                        errors++;
                        $display("FAIL %s emit got data=%h mask=%h want data=%h mask=%h",
                                 tag, out_data, out_mask, e.data, e.mask);
                    end
                end
            end
            if (done === 1'b1) begin
                saw_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (saw_done !== 1'b1) begin
            errors++; $display("FAIL %s done_timeout got=0 want=1", tag);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL %s leftover_emits got=%0d want=0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic load_basic();
        prog_write(8'd0, enc(4'h7, 4'd2, 4'd1, 4'd0, 16'd5));
        prog_write(8'd1, enc(4'hC, 4'd0, 4'd2, 4'd0, 16'd0));
        prog_write(8'd2, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({prog_ready, start_ready, busy, done, err, out_valid} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_ctrl got pr/sr/busy/done/err/ov=%b want=110000",
                     {prog_ready, start_ready, busy, done, err, out_valid});
        end
        checks++;
        if (out_data !== '0 || out_mask !== '0) begin
            errors++; $display("FAIL reset_outputs got data=%h mask=%h want 0", out_data, out_mask);
        end
    endtask

    task automatic test_basic_emit();
        logic [NL*DW-1:0] sd, ex;
        int fe;
        load_basic();
        for (int i = 0; i < NL; i++) begin
            sd[i*DW +: DW] = DW'(i);
            ex[i*DW +: DW] = DW'(i + 5);
        end
        push_exp(ex, 8'hFF);
        launch(8'd0, sd, 8'hFF);
        run_until_done("basic", 100, fe);
        checks++;
        if (fe !== 5) begin
            errors++; $display("FAIL basic_latency got=%0d want=5", fe);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL basic_err got=%b want=0", err);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL basic_after got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_backpressure();
        logic [NL*DW-1:0] sd, ex, snap;
        int fe;
        for (int i = 0; i < NL; i++) begin
            sd[i*DW +: DW] = DW'(32'h1000 * i + 7);
            ex[i*DW +: DW] = DW'(32'h1000 * i + 12);
        end
        out_ready = 1'b0;
        push_exp(ex, 8'hFF);
        launch(8'd0, sd, 8'hFF);
        for (int c = 0; c < 50; c++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        snap = out_data;
        checks++;
        if (out_valid !== 1'b1 || snap !== ex) begin
            errors++; $display("FAIL bp_first got valid=%b data=%h want 1 data=%h", out_valid, snap, ex);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== snap || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got valid=%b done=%b busy=%b data=%h want 1/0/1 data=%h",
                         c, out_valid, done, busy, out_data, snap);
            end
        end
        out_ready = 1'b1;
        run_until_done("backpressure", 50, fe);
    endtask

    task automatic test_setmask();
        logic [NL*DW-1:0] sd, ex;
        int fe;
        prog_write(8'd16, enc(4'h9, 4'd0, 4'd1, 4'd0, 16'd0));
        prog_write(8'd17, enc(4'h7, 4'd1, 4'd1, 4'd0, 16'd100));
        prog_write(8'd18, enc(4'hA, 4'd0, 4'd0, 4'd0, 16'd0));
        prog_write(8'd19, enc(4'hC, 4'd0, 4'd1, 4'd0, 16'd0));
        prog_write(8'd20, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
        for (int i = 0; i < NL; i++) begin
            sd[i*DW +: DW] = DW'(i % 2);
            ex[i*DW +: DW] = (i % 2 == 1) ? DW'(101) : '0;
        end
        push_exp(ex, 8'hFF);
        launch(8'd16, sd, 8'hFF);
        run_until_done("setmask", 100, fe);
    endtask

    task automatic branch_case(input string tag, input logic [NL*DW-1:0] sd,
                               input logic [NL-1:0] m, input int n_before);
        int fe;
        push_exp('0, m);
        launch(8'd32, sd, m);
        run_until_done(tag, 200, fe);
        checks++;
        if (fe !== 2 * n_before + 3) begin
            errors++; $display("FAIL %s latency got=%0d want=%0d", tag, fe, 2 * n_before + 3);
        end
    endtask

    task automatic test_branch();
        logic [NL*DW-1:0] sd;
        prog_write(8'd32, enc(4'h7, 4'd1, 4'd1, 4'd0, 16'hFFFF));
        prog_write(8'd33, enc(4'hB, 4'd0, 4'd1, 4'd0, 16'hFFFF));
        prog_write(8'd34, enc(4'hC, 4'd0, 4'd1, 4'd0, 16'd0));
        prog_write(8'd35, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
        for (int i = 0; i < NL; i++) sd[i*DW +: DW] = DW'(3);
        branch_case("loop3", sd, 8'hFF, 6);
        for (int i = 0; i < NL; i++) sd[i*DW +: DW] = (i < 4) ? DW'(2) : DW'(9);
        branch_case("loop_partial", sd, 8'h0F, 4);
        for (int i = 0; i < NL; i++) sd[i*DW +: DW] = DW'(3);
        branch_case("mask_zero", sd, 8'h00, 2);
    endtask

    task automatic test_alu();
        logic [NL*DW-1:0] sd, e7, e9;
        logic [DW-1:0] s, r3, r4, r5, r6, r7;
        int fe;
        prog_write(8'd80, enc(4'h8, 4'd3, 4'd0, 4'd0, 16'h0001));
        prog_write(8'd81, enc(4'h1, 4'd4, 4'd1, 4'd3, 16'd0));
        prog_write(8'd82, enc(4'h5, 4'd5, 4'd4, 4'd0, 16'd0));
        prog_write(8'd83, enc(4'h6, 4'd6, 4'd1, 4'd1, 16'd0));
        prog_write(8'd84, enc(4'h4, 4'd7, 4'd6, 4'd5, 16'd0));
        prog_write(8'd85, enc(4'h2, 4'd8, 4'd7, 4'd3, 16'd0));
        prog_write(8'd86, enc(4'h3, 4'd9, 4'd8, 4'd5, 16'd0));
        prog_write(8'd87, enc(4'h7, 4'd0, 4'd1, 4'd0, 16'd7));
        prog_write(8'd88, enc(4'hC, 4'd0, 4'd7, 4'd0, 16'd0));
        prog_write(8'd89, enc(4'hC, 4'd0, 4'd9, 4'd0, 16'd0));
        prog_write(8'd90, enc(4'hC, 4'd0, 4'd0, 4'd0, 16'd0));
        prog_write(8'd91, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
        for (int i = 0; i < NL; i++) begin
            s  = DW'(32'h9001 * i);
            r3 = 32'h0001_0000;
            r4 = s - r3;
            r5 = ($signed(r4) < 0) ? 32'd1 : 32'd0;
            r6 = s * s;
            r7 = r6 ^ r5;
            sd[i*DW +: DW] = s;
            e7[i*DW +: DW] = r7;
            e9[i*DW +: DW] = (r7 & r3) | r5;
        end
        push_exp(e7, 8'hFF);
        push_exp(e9, 8'hFF);
        push_exp('0, 8'hFF);
        launch(8'd80, sd, 8'hFF);
        run_until_done("alu", 300, fe);
    endtask

    task automatic test_illegal();
        logic [NL*DW-1:0] sd, ex;
        int fe;
        prog_write(8'd48, enc(4'hD, 4'd1, 4'd1, 4'd1, 16'd0));
        prog_write(8'd49, enc(4'hE, 4'd1, 4'd1, 4'd1, 16'd0));
        for (int i = 0; i < NL; i++) begin
            sd[i*DW +: DW] = DW'(i + 20);
            ex[i*DW +: DW] = DW'(i + 25);
        end
        for (int k = 0; k < 2; k++) begin
            launch(8'(48 + k), sd, 8'hFF);
            run_until_done("illegal", 50, fe);
            checks++;
            if (err !== 1'b1 || fe !== -1) begin
                errors++; $display("FAIL illegal_%0d got err=%b emit=%0d want err=1 emit=-1", k, err, fe);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b1) begin
                errors++; $display("FAIL illegal_idle got busy=%b done=%b err=%b want 0/0/1", busy, done, err);
            end
        end
        push_exp(ex, 8'hFF);
        launch(8'd0, sd, 8'hFF);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_clear got=%b want=0", err);
        end
        run_until_done("relaunch", 100, fe);
    endtask

    task automatic test_back_to_back();
        logic [NL*DW-1:0] sd, ex;
        int fe;
        prog_write(8'd60, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
        prog_write(8'd61, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
        for (int i = 0; i < NL; i++) begin
            sd[i*DW +: DW] = DW'(100 + i);
            ex[i*DW +: DW] = (i % 2 == 1) ? DW'(100 + i) : '0;
        end
        @(negedge clk);
        prog_valid = 1'b1; prog_addr = 8'd60; prog_data = enc(4'hC, 4'd0, 4'd1, 4'd0, 16'd0);
        start_valid = 1'b1; start_pc = 8'd60; start_data = sd; start_mask = 8'hAA;
        #1;
        checks++;
        if (prog_ready !== 1'b1 || start_ready !== 1'b0) begin
            errors++; $display("FAIL collide got prog_ready=%b start_ready=%b want 1/0", prog_ready, start_ready);
        end
        @(negedge clk);
        prog_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || start_ready !== 1'b1) begin
            errors++; $display("FAIL collide_next got busy=%b start_ready=%b want 0/1", busy, start_ready);
        end
        push_exp(ex, 8'hAA);
        @(negedge clk);
        start_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL collide_launch got busy=%b want 1", busy);
        end
        run_until_done("collide", 100, fe);
    endtask

    task automatic test_reset_mid_emit();
        logic [NL*DW-1:0] sd;
        for (int i = 0; i < NL; i++) sd[i*DW +: DW] = DW'(i);
        out_ready = 1'b0;
        launch(8'd0, sd, 8'hFF);
        for (int c = 0; c < 50; c++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_emit_reach got out_valid=%b want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_mid got valid=%b busy=%b done=%b data=%h want 0/0/0/0",
                     out_valid, busy, done, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1 || prog_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_after cyc=%0d got done=%b busy=%b sr=%b pr=%b want 0/0/1/1",
                         c, done, busy, start_ready, prog_ready);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; prog_valid = 1'b0; prog_addr = '0; prog_data = '0;
        start_valid = 1'b0; start_pc = '0; start_data = '0; start_mask = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic_emit();
        test_backpressure();
        test_setmask();
        test_branch();
        test_alu();
        test_illegal();
        test_back_to_back();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
